// File: rtl/shift_arbiter_if.sv
// Request/config/result bundle for shift_arbiter; the slave modport is the arbiter side.
interface shift_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int IN_WIDTH   = 10,
  parameter int IN_S_WIDTH = 3,
  parameter int OUT_WIDTH  = 15
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          i_req_valid;
  logic [NUM_REQ-1:0]          o_req_ready;
  logic [NUM_REQ*IN_WIDTH-1:0] i_req_data;
  logic                        i_cfg_we;
  logic [ID_WIDTH-1:0]         i_cfg_id;
  logic [IN_S_WIDTH-1:0]       i_cfg_shift;
  logic                        o_valid;
  logic                        i_ready;
  logic [OUT_WIDTH-1:0]        o_data;
  logic [ID_WIDTH-1:0]         o_id;
  logic                        o_idle;

  modport slave (
    input  i_req_valid, i_req_data, i_cfg_we, i_cfg_id, i_cfg_shift, i_ready,
    output o_req_ready, o_valid, o_data, o_id, o_idle
  );

  modport master (
    output i_req_valid, i_req_data, i_cfg_we, i_cfg_id, i_cfg_shift, i_ready,
    input  o_req_ready, o_valid, o_data, o_id, o_idle
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one arithmetic right shifter; result two cycles after the grant cycle,
// up to two results held while i_ready=0. Define SHIFT_ROUND_EN for round-half-up shifting.
module shift_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IN_WIDTH   = 10,
  parameter int IN_S_WIDTH = 3,
  parameter int TAIL_BIT   = 5,
  parameter int OUT_WIDTH  = 15
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  shift_arbiter_if.slave bus
);
  localparam int ID_WIDTH = $clog2(NUM_REQ);

  generate
    if (OUT_WIDTH != IN_WIDTH + TAIL_BIT) begin : g_width_chk
      $error("shift_arbiter: OUT_WIDTH must equal IN_WIDTH + TAIL_BIT");
    end
  endgenerate

  logic [IN_S_WIDTH-1:0] shift_q [NUM_REQ];
  logic [IN_S_WIDTH-1:0] shift_d [NUM_REQ];
  logic [ID_WIDTH-1:0]   ptr_q, ptr_d;

  logic                  s1_vld_q, s1_vld_d;
  logic [IN_WIDTH-1:0]   s1_dat_q, s1_dat_d;
  logic [IN_S_WIDTH-1:0] s1_shift_q, s1_shift_d;
  logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;

  logic                  s2_vld_q, s2_vld_d;
  logic [OUT_WIDTH-1:0]  s2_dat_q, s2_dat_d;
  logic [ID_WIDTH-1:0]   s2_id_q, s2_id_d;

  logic                  cand_vld;
  logic [ID_WIDTH-1:0]   cand_id;
  int                    idx;
  logic                  s2_load, s1_adv, s1_load_ok, hs;
  logic signed [OUT_WIDTH-1:0] pre, shifted;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!cand_vld && bus.i_req_valid[ID_WIDTH'(idx)]) begin
        cand_vld = 1'b1;
        cand_id  = ID_WIDTH'(idx);
      end
    end
  end

  assign s2_load    = !s2_vld_q || bus.i_ready;
  assign s1_adv     = s1_vld_q && s2_load;
  assign s1_load_ok = !s1_vld_q || s1_adv;
  // Gated by reset so no grant is offered while the pipeline is held in reset.
  assign hs         = cand_vld && s1_load_ok && i_rst_n;

  always_comb begin
    bus.o_req_ready = '0;
    if (hs) bus.o_req_ready[cand_id] = 1'b1;
  end

  assign pre = OUT_WIDTH'(s1_dat_q) << TAIL_BIT;

`ifdef SHIFT_ROUND_EN
  logic signed [OUT_WIDTH:0] rnd_inc, rnd_sum;

  always_comb begin
    rnd_inc = '0;
    if (s1_shift_q != '0) rnd_inc = (OUT_WIDTH+1)'(1) << (s1_shift_q - 1'b1);
    rnd_sum = {pre[OUT_WIDTH-1], pre} + rnd_inc;
    shifted = OUT_WIDTH'(rnd_sum >>> s1_shift_q);
  end
`else
  assign shifted = pre >>> s1_shift_q;
`endif

  always_comb begin
    shift_d = shift_q;
    if (bus.i_cfg_we && (int'(bus.i_cfg_id) < NUM_REQ)) shift_d[bus.i_cfg_id] = bus.i_cfg_shift;

    ptr_d = ptr_q;
    if (hs) begin
      if (int'(cand_id) == NUM_REQ - 1) ptr_d = '0;
      else                              ptr_d = cand_id + 1'b1;
    end

    s1_vld_d   = s1_vld_q;
    s1_dat_d   = s1_dat_q;
    s1_shift_d = s1_shift_q;
    s1_id_d    = s1_id_q;
    // Shift is taken from the registered file, so a same-cycle write is not seen.
    if (hs) begin
      s1_vld_d   = 1'b1;
      s1_dat_d   = bus.i_req_data[cand_id*IN_WIDTH +: IN_WIDTH];
      s1_shift_d = shift_q[cand_id];
      s1_id_d    = cand_id;
    end else if (s1_adv) begin
      s1_vld_d = 1'b0;
    end

    s2_vld_d = s2_vld_q;
    s2_dat_d = s2_dat_q;
    s2_id_d  = s2_id_q;
    if (s2_load) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_dat_d = shifted;
        s2_id_d  = s1_id_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shift_q    <= '{default: '0};
      ptr_q      <= '0;
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      s1_shift_q <= '0;
      s1_id_q    <= '0;
      s2_vld_q   <= 1'b0;
      s2_dat_q   <= '0;
      s2_id_q    <= '0;
    end else begin
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      s1_vld_q   <= s1_vld_d;
      s1_dat_q   <= s1_dat_d;
      s1_shift_q <= s1_shift_d;
      s1_id_q    <= s1_id_d;
      s2_vld_q   <= s2_vld_d;
      s2_dat_q   <= s2_dat_d;
      s2_id_q    <= s2_id_d;
    end
  end

  assign bus.o_valid = s2_vld_q;
  assign bus.o_data  = s2_dat_q;
  assign bus.o_id    = s2_id_q;
  assign bus.o_idle  = !s1_vld_q && !s2_vld_q;
endmodule
